// File: rtl/exp_arb_pkg.sv
// Shared types and widths for the exponentiation-unit arbiter.
package exp_arb_pkg;

    localparam int unsigned OP_W  = 4;
    localparam int unsigned RES_W = 16;
    localparam int unsigned TO_W  = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoadN,
        StLoadX,
        StWaitBusy,
        StWaitDone,
        StResp
    } arb_state_e;

endpackage

// File: rtl/exp_unit_arbiter_rr_pick.sv
// Round-robin pick: first set request bit scanning upward from ptr_i, wrapping at NREQ.
module rr_pick #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic [NREQ-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [NREQ-1:0]  win_oh_o,
    output logic [IDX_W-1:0] win_idx_o,
    output logic             win_any_o
);

    logic [IDX_W:0] pos;
    logic           found;

    always_comb begin
        win_oh_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        pos       = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            // ptr_i < NREQ and i < NREQ, so one conditional subtract is enough to wrap.
            pos = {1'b0, ptr_i} + (IDX_W + 1)'(i);
            if (pos >= (IDX_W + 1)'(NREQ)) begin
                pos = pos - (IDX_W + 1)'(NREQ);
            end
            if (!found && req_i[pos[IDX_W-1:0]]) begin
                found                        = 1'b1;
                win_idx_o                    = pos[IDX_W-1:0];
                win_oh_o[pos[IDX_W-1:0]]     = 1'b1;
            end
        end
        win_any_o = found;
    end

endmodule

// File: rtl/exp_unit_arbiter.sv
// Round-robin arbiter that shares one exponentiation unit among NREQ requesters and
// sequences its two-beat start/bus load (n then x), then returns the result with a done pulse.
module exp_unit_arbiter
    import exp_arb_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [OP_W*NREQ-1:0] req_x,
    input  logic [OP_W*NREQ-1:0] req_n,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [RES_W-1:0]     result,
    output logic                 err,
    output logic                 busy,
    output logic                 exp_start,
    output logic [OP_W-1:0]      exp_bus,
    input  logic                 exp_ready,
    input  logic [RES_W-1:0]     exp_y
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e         state_q, state_d;
    logic [NREQ-1:0]    gnt_q, gnt_d;
    logic [NREQ-1:0]    done_q, done_d;
    logic [RES_W-1:0]   result_q, result_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               exp_start_q, exp_start_d;
    logic [OP_W-1:0]    exp_bus_q, exp_bus_d;
    logic [OP_W-1:0]    x_q, x_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [TO_W-1:0]    cnt_q, cnt_d;

    logic [NREQ-1:0]    pick_oh;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [TO_W-1:0]    cnt_inc;
    logic               to_hit;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .win_oh_o  (pick_oh),
        .win_idx_o (pick_idx),
        .win_any_o (pick_any)
    );

    assign cnt_inc = cnt_q + 1'b1;
    assign to_hit  = (cnt_inc == TO_W'(TIMEOUT));

    // Outputs are registered, so they are decoded from the state being entered.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        idx_d       = idx_q;
        x_d         = x_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        done_d      = '0;
        result_d    = '0;
        err_d       = 1'b0;
        exp_start_d = 1'b0;
        exp_bus_d   = '0;

        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d     = StLoadN;
                    gnt_d       = pick_oh;
                    idx_d       = pick_idx;
                    x_d         = req_x[OP_W*int'(pick_idx) +: OP_W];
                    // exp_bus_q doubles as the latch for n during the LOAD_N beat.
                    exp_start_d = 1'b1;
                    exp_bus_d   = req_n[OP_W*int'(pick_idx) +: OP_W];
                end
            end
            StLoadN: begin
                state_d     = StLoadX;
                exp_start_d = 1'b1;
                exp_bus_d   = x_q;
            end
            StLoadX: begin
                state_d = StWaitBusy;
                cnt_d   = '0;
            end
            StWaitBusy: begin
                if (!exp_ready) begin
                    state_d = StWaitDone;
                    cnt_d   = '0;
                end else if (to_hit) begin
                    state_d = StResp;
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StWaitDone: begin
                if (exp_ready) begin
                    state_d  = StResp;
                    done_d   = gnt_q;
                    result_d = exp_y;
                end else if (to_hit) begin
                    state_d = StResp;
                    done_d  = gnt_q;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StResp: begin
                state_d = StIdle;
                gnt_d   = '0;
                ptr_d   = (idx_q == IDX_W'(NREQ - 1)) ? '0 : idx_q + 1'b1;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            gnt_q       <= '0;
            done_q      <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            busy_q      <= 1'b0;
            exp_start_q <= 1'b0;
            exp_bus_q   <= '0;
            x_q         <= '0;
            idx_q       <= '0;
            ptr_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            result_q    <= result_d;
            err_q       <= err_d;
            busy_q      <= busy_d;
            exp_start_q <= exp_start_d;
            exp_bus_q   <= exp_bus_d;
            x_q         <= x_d;
            idx_q       <= idx_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign gnt       = gnt_q;
    assign done      = done_q;
    assign result    = result_q;
    assign err       = err_q;
    assign busy      = busy_q;
    assign exp_start = exp_start_q;
    assign exp_bus   = exp_bus_q;

endmodule

// File: tb/tb_exp_unit_arbiter.sv
// Randomized self-checking bench for exp_unit_arbiter with a behavioural exp unit.
module tb_exp_unit_arbiter;

    localparam int NREQ = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [3:0]    req = '0;
    logic [15:0]   req_x = '0;
    logic [15:0]   req_n = '0;
    logic [3:0]    gnt, done;
    logic [15:0]   result;
    logic          err, busy, exp_start;
    logic [3:0]    exp_bus;
    logic          exp_ready;
    logic [15:0]   exp_y;

    int n_vec = 0;
    int n_err = 0;
    int ptr   = 0;   // reference round-robin pointer
    int lat   = 3;   // unit compute cycles
    bit stuck = 1'b0;

    exp_unit_arbiter #(.NREQ(NREQ), .TIMEOUT(255)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_x     (req_x),
        .req_n     (req_n),
        .gnt       (gnt),
        .done      (done),
        .result    (result),
        .err       (err),
        .busy      (busy),
        .exp_start (exp_start),
        .exp_bus   (exp_bus),
        .exp_ready (exp_ready),
        .exp_y     (exp_y)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] pow16(input logic [3:0] b, input logic [3:0] e);
        logic [15:0] r;
        r = 16'd1;
        for (int i = 0; i < int'(e); i++) r = r * 16'(b);
        return r;
    endfunction

    // Behavioural exp unit: takes n then x on two start beats, computes for lat cycles.
    logic [3:0] m_n, m_x;
    bit         m_phase;
    int         m_left;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            exp_ready <= 1'b1;
            exp_y     <= '0;
            m_phase   <= 1'b0;
            m_left    <= 0;
            m_n       <= '0;
            m_x       <= '0;
        end else if (exp_start) begin
            if (!m_phase) begin
                m_n     <= exp_bus;
                m_phase <= 1'b1;
            end else begin
                m_x     <= exp_bus;
                m_phase <= 1'b0;
                if (!stuck) begin
                    exp_ready <= 1'b0;
                    m_left    <= lat;
                end
            end
        end else if (!exp_ready) begin
            if (m_left <= 1) begin
                exp_ready <= 1'b1;
                exp_y     <= pow16(m_x, m_n);
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic do_reset;
        rst = 1'b0;
        repeat (2) tick();
        check("reset_outs", {1'b0, gnt, done, result, err, busy, exp_start, exp_bus}, 32'd0);
        rst = 1'b1;
        ptr = 0;
        tick();
    endtask

    // Serves one transaction; returns winner index and cycles waited for the grant.
    task automatic serve_one(input bit chg, output int widx, output int wait_c);
        int          idx;
        int          c;
        logic [3:0]  xo, no;
        logic [15:0] exp_res;
        bit          exp_err;
        wait_c = 0;
        while (gnt == 4'd0 && wait_c < 20) begin
            tick();
            wait_c++;
        end
        widx = -1;
        if (gnt == 4'd0) begin
            check("grant_timeout", 32'd0, 32'd1);
            return;
        end
        idx = -1;
        for (int i = 0; i < NREQ; i++) begin
            int j;
            j = (ptr + i) % NREQ;
            if (idx < 0 && req[j]) idx = j;
        end
        if (idx < 0) begin
            check("spurious_grant", 32'(gnt), 32'd0);
            return;
        end
        widx = idx;
        xo = req_x[4*idx +: 4];
        no = req_n[4*idx +: 4];
        exp_err = stuck;
        exp_res = stuck ? 16'd0 : pow16(xo, no);
        check("gnt", 32'(gnt), 32'(1 << idx));
        check("load_n", {26'd0, busy, exp_start, exp_bus}, {26'd0, 1'b1, 1'b1, no});
        tick();
        check("load_x", {27'd0, exp_start, exp_bus}, {27'd0, 1'b1, xo});
        c = 1;
        while (done == 4'd0 && c < 300) begin
            tick();
            c++;
            if (chg && c == 3) begin
                req_x = 16'($urandom);
                req_n = 16'($urandom);
                req   = '0;
            end
        end
        check("done", 32'(done), 32'(1 << idx));
        check("resp", {11'd0, gnt, result, err}, {11'd0, 4'(1 << idx), exp_res, exp_err});
        check("latency", 32'(c), stuck ? 32'd257 : 32'(3 + lat));
        ptr = (idx + 1) % NREQ;
        tick();
        check("post_resp", {9'd0, gnt, done, result, err, busy}, 32'd0);
    endtask

    int w, wc;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Single request: 3^4 = 81.
        req_x = 16'h0003; req_n = 16'h0004; req = 4'b0001; lat = 3;
        serve_one(1'b0, w, wc);
        check("single_res_ref", 32'(pow16(4'd3, 4'd4)), 32'h51);
        req = '0;

        // Simultaneous requests after reset.
        do_reset();
        req_x = 16'h0052; req_n = 16'h0023; req = 4'b0011;
        serve_one(1'b0, w, wc);
        check("simul_first", 32'(w), 32'd0);
        req[0] = 1'b0;
        serve_one(1'b0, w, wc);
        check("simul_second", 32'(w), 32'd1);
        req = '0;

        // Fairness with all four held.
        do_reset();
        req_x = 16'h9a52; req_n = 16'h3123; req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            lat = $urandom_range(1, 6);
            serve_one(1'b0, w, wc);
            check("fair_order", 32'(w), 32'(k % 4));
            if (k > 0) check("fair_gap", 32'(wc), 32'd1);
        end
        req = '0;
        tick();

        // Timeout: the unit never drops ready.
        stuck = 1'b1;
        req = 4'b0100;
        serve_one(1'b0, w, wc);
        stuck = 1'b0;
        req = '0;
        tick();

        // Operand change after grant and n = 0.
        lat = 4;
        req_x = 16'h0700; req_n = 16'h0000; req = 4'b0100;
        ptr = 3;
        do_reset();
        serve_one(1'b1, w, wc);
        check("chg_winner", 32'(w), 32'd2);

        // Randomized services.
        for (int it = 0; it < 30; it++) begin
            if (req == 4'd0 || $urandom_range(0, 1) == 1) req = 4'($urandom_range(1, 15));
            req_x = 16'($urandom);
            req_n = 16'($urandom);
            lat = $urandom_range(1, 6);
            serve_one(1'b0, w, wc);
            if (w >= 0 && $urandom_range(0, 1) == 1) req[w] = 1'b0;
        end
        req = '0;
        tick();

        // Reset during WAIT_DONE aborts silently; pointer returns to 0.
        lat = 30;
        req_x = 16'h1234; req_n = 16'h5678; req = 4'b0001;
        while (gnt == 4'd0 && wc < 40) begin tick(); wc++; end
        repeat (5) tick();
        check("mid_busy", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1 check("async_clear", {1'b0, gnt, done, result, err, busy, exp_start, exp_bus}, 32'd0);
        req = 4'b0100;
        tick();
        tick();
        check("reset_silent", {27'd0, done, err}, 32'd0);
        rst = 1'b1;
        ptr = 0;
        lat = 2;
        serve_one(1'b0, w, wc);
        check("after_reset_winner", 32'(w), 32'd2);
        req = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
